// File: rtl/r2r_dac_sequencer_if.sv
// Host sample stream into the R2R DAC sequencer: 8-bit samples behind a valid/ready handshake.
interface r2r_dac_sequencer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/r2r_dac_sequencer.sv
// Sample sequencer for the 8-bit R2R DAC: programmable tick divider feeding either a
// buffered host stream or an internal sawtooth/triangle generator.
module r2r_dac_sequencer #(
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [1:0]            mode,
    input  logic [DIV_W-1:0]      rate,
    input  logic [7:0]            step,
    input  logic                  flush,
    r2r_dac_sequencer_if.slave    strm,
    output logic [7:0]            dac_code,
    output logic                  upd,
    output logic                  underrun,
    output logic [AW:0]           fifo_level
);

    typedef enum logic [1:0] {
        ModeHold   = 2'b00,
        ModeStream = 2'b01,
        ModeSaw    = 2'b10,
        ModeTri    = 2'b11
    } mode_e;

    mode_e            mode_in;
    mode_e            mode_q;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [7:0]       code_q, code_d;
    logic             dir_q, dir_d;
    logic             upd_q, upd_d;
    logic             underrun_q, underrun_d;
    logic [AW:0]      level_q, level_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic       mode_chg;
    logic       tick;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic [8:0] sum9;

    assign mode_in    = mode_e'(mode);
    assign mode_chg   = (mode_in != mode_q);
    // A mode switch restarts the divider and swallows any tick in that cycle.
    assign tick       = ena && !mode_chg && (cnt_q == rate);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (AW+1)'(FIFO_DEPTH));

    assign strm.s_ready = !rst && !fifo_full;
    assign push         = strm.s_valid && strm.s_ready && !flush;
    assign pop          = tick && (mode_in == ModeStream) && !fifo_empty && !flush;

    assign sum9 = {1'b0, code_q} + {1'b0, step};

    always_comb begin
        cnt_d      = cnt_q;
        code_d     = code_q;
        dir_d      = dir_q;
        upd_d      = 1'b0;
        underrun_d = underrun_q;

        if (mode_chg) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (ena) begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        if (mode_chg && (mode_in == ModeTri)) begin
            dir_d = 1'b0;
        end

        if (tick) begin
            case (mode_in)
                ModeHold: begin
                end
                ModeStream: begin
                    // A flush cancels the pop entirely, including the underrun report.
                    if (!flush) begin
                        if (!fifo_empty) begin
                            code_d = mem_q[rd_ptr_q];
                            upd_d  = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                end
                ModeSaw: begin
                    code_d = sum9[7:0];
                    upd_d  = 1'b1;
                end
                ModeTri: begin
                    upd_d = 1'b1;
                    if (step != 8'h00) begin
                        if (!dir_q) begin
                            if (sum9 >= 9'd255) begin
                                code_d = 8'hFF;
                                dir_d  = 1'b1;
                            end else begin
                                code_d = sum9[7:0];
                            end
                        end else if (code_q <= step) begin
                            code_d = 8'h00;
                            dir_d  = 1'b0;
                        end else begin
                            code_d = code_q - step;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= ModeHold;
            cnt_q      <= '0;
            code_q     <= 8'h00;
            dir_q      <= 1'b0;
            upd_q      <= 1'b0;
            underrun_q <= 1'b0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            mode_q     <= mode_in;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            dir_q      <= dir_d;
            upd_q      <= upd_d;
            underrun_q <= underrun_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Sample storage needs no reset; occupancy is tracked by level_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= strm.s_data;
        end
    end

    assign dac_code   = code_q;
    assign upd        = upd_q;
    assign underrun   = underrun_q;
    assign fifo_level = level_q;

endmodule

// File: doc/r2r_dac_sequencer.md
# r2r_dac_sequencer

Digital sample sequencer for the 8-bit R2R DAC. It produces the DAC input code `dac_code[7:0]`, which feeds the DAC `d0..d7` inputs, at a programmable sample rate. The code comes from one of two sources: a host sample stream, buffered in a small FIFO behind a valid/ready handshake, or an internal sawtooth/triangle generator. It is the only block that drives the R2R DAC inputs and sits between the host-facing digital pins and the analog macro.

## Interface

Parameters:

- `DIV_W`, default 8: width of the sample-rate divider.
- `FIFO_DEPTH`, default 4: stream FIFO depth in samples. Must be a power of two, at least 2.

Ports:

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ena`  in  1  tick enable. While low, the divider is frozen and no ticks occur.
- `mode`  in  2  source select: 00 HOLD, 01 STREAM, 10 SAW, 11 TRI.
- `rate`  in  DIV_W  sample period minus one, in clocks.
- `step`  in  8  per-tick increment for SAW and TRI.
- `flush`  in  1  synchronous FIFO clear.
- `s_data`  in  8  stream sample.
- `s_valid`  in  1  stream sample valid.
- `s_ready`  out  1  FIFO can accept a sample.
- `dac_code`  out  8  registered DAC code, drives R2R `d0..d7`.
- `upd`  out  1  one-cycle pulse; high in the first cycle a new `dac_code` is visible.
- `underrun`  out  1  sticky flag: a STREAM tick found the FIFO empty.
- `fifo_level`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation

- **Divider.** Counter `cnt` runs from 0 to `rate` while `ena`=1. The internal `tick` is high when `cnt==rate && ena`; on that edge `cnt` returns to 0.
  - `rate`=0 gives a tick every cycle.
  - When `mode` differs from its value registered on the previous cycle, `cnt` is forced to 0 and no tick occurs that cycle.
- **HOLD.** `dac_code` holds its value. The FIFO still accepts pushes.
- **STREAM.** On a tick with FIFO non-empty: pop the head into `dac_code`. On a tick with FIFO empty: `dac_code` holds and `underrun` is set to 1.
- **SAW.** On a tick, `dac_code` ← (`dac_code` + `step`) mod 256. It wraps: 0xFE + 4 gives 0x02.
- **TRI.** Uses a direction bit `dir` (0 = up). `dir` is cleared to 0 on every mode change into TRI.
  - Up: if `dac_code + step` ≥ 255 (9-bit compare), set `dac_code` = 255 and `dir` = 1; otherwise add `step`.
  - Down: if `dac_code` ≤ `step`, set `dac_code` = 0 and `dir` = 0; otherwise subtract `step`.
  - `step`=0: the code holds and `dir` does not change.
- **Mode entry.** SAW and TRI continue from the current `dac_code`; there is no reload. Leaving STREAM keeps the FIFO contents.
- **FIFO.**
  - Handshake: `s_ready` = !full, where full is computed from registered occupancy. A push happens when `s_valid && s_ready`.
  - Push and pop in the same cycle: both take effect and the level is unchanged.
  - When full, no push is accepted even if a pop happens in the same cycle.
  - Push into an empty FIFO on a STREAM tick: the pop sees empty, so `underrun` is set and the pushed sample is stored.
  - `flush`: level becomes 0 on the next edge. `flush` has priority over push and pop in the same cycle. Any pop that cycle is cancelled, so `dac_code` holds and `underrun` is not set by that tick.
- **upd.** Registered. High in the cycle after every tick whose mode is STREAM (non-empty), SAW, or TRI, even if the resulting value equals the old one. Low otherwise.

## Timing

- **Reset.** `rst` high at an edge sets:
  - `dac_code`=0x00, `cnt`=0, `dir`=0;
  - FIFO empty, `fifo_level`=0;
  - `underrun`=0, `upd`=0, registered mode = HOLD.

  `s_ready` is 0 while `rst`=1 and 1 from the first cycle after release.
- **Reset mid-operation.** Any in-flight sample is discarded. The FIFO is emptied, and the DAC returns to code 0 one edge later.
- **Stream latency.**
  - Sample accepted at edge N: visible in `fifo_level` after edge N.
  - That sample can be popped by a tick at edge N+1 or later. It appears on `dac_code` after that tick's edge, with `upd` high in the same cycle.
- **Tick period.** `rate`+1 clocks while `ena`=1. Changing `rate` mid-count takes effect at the next compare; if `cnt` > new `rate`, the count runs up to 2^DIV_W−1, wraps to 0, and continues.
- **underrun.** Cleared only by `rst`.

## Test plan

- Reset, then STREAM with `rate`=3 and `ena`=1; push 0x10, 0x20, 0x30 → `dac_code` steps 0x10, 0x20, 0x30 at 4-clock spacing with one `upd` pulse each. The next tick sets `underrun`=1 and `dac_code` stays 0x30.
- With `rate`=255, push 5 samples back-to-back with `s_valid`=1 → `s_ready` drops after the 4th; `fifo_level`=4; the 5th is held until a tick pops. Then assert `flush` → `fifo_level`=0 and `s_ready`=1 on the next cycle.
- SAW with `rate`=0, `step`=4, starting from 0xFC → `dac_code` 0x00, 0x04, 0x08 on consecutive cycles.
- TRI with `rate`=0, `step`=0x60, starting at 0 → 0x60, 0xC0, 0xFF, 0x9F, 0x3F, 0x00, 0x60.
- Drop `ena` mid-count for 10 cycles → no tick and no `upd` during that time; the count resumes from the frozen `cnt`. Switch mode SAW→HOLD → no tick on the switch cycle and `dac_code` frozen.
- Assert `rst` for one cycle during SAW with 2 samples queued → next cycle `dac_code`=0, `fifo_level`=0, `underrun`=0, `upd`=0.
